// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU MEM stage
// (port C) and a DMA/loader master (port D). One command is issued per cycle.
// Read data is returned one cycle later to whichever master issued the read.
// The CPU has fixed priority. That priority is bounded by a starvation counter
// per port. The DMA can keep ownership across a burst by holding d_lock.
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata   CPU command, c_gnt accepts it (combinational)
//   c_rvalid             rdata carries the CPU read result (registered)
//   d_req/d_we/d_addr/d_wdata   DMA command, d_gnt accepts it (combinational)
//   d_lock               DMA asks to keep ownership for its next beat
//   d_rvalid             rdata carries the DMA read result (registered)
//   rdata                shared read data (mem_rdata, forced to 0 in reset)
//   mem_addr/mem_wdata/mem_read/mem_write   memory command
//   mem_rdata            synchronous memory read data
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic                  d_lock,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {OWN_IDLE, OWN_CPU, OWN_DMA} owner_t;
  typedef enum logic [1:0] {RD_NONE, RD_C, RD_D} rd_pend_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_t     owner;
  rd_pend_t   rd_pend;
  logic [3:0] c_wait;
  logic [3:0] d_wait;
  logic       c_win;
  logic       d_win;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v >= LIMIT) return LIMIT;
    return v + 4'd1;
  endfunction

  // Arbitration: a starved DMA wins first. A locked DMA burst then keeps the
  // port only while the CPU has not yet waited STARVE_LIMIT cycles.
  always_comb begin
    c_win = 1'b0;
    d_win = 1'b0;
    if (c_req && d_req) begin
      if (d_wait == LIMIT)
        d_win = 1'b1;
      else if (owner == OWN_DMA && d_lock && c_wait < LIMIT)
        d_win = 1'b1;
      else
        c_win = 1'b1;
    end else if (c_req) begin
      c_win = 1'b1;
    end else if (d_req) begin
      d_win = 1'b1;
    end
  end

  // Grants are gated by reset so nothing reaches memory while reset is low.
  assign c_gnt = c_win & reset;
  assign d_gnt = d_win & reset;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (c_gnt) begin
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_read  = ~c_we;
      mem_write = c_we;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_read  = ~d_we;
      mem_write = d_we;
    end
  end

  // Command stage -> read-return stage: remember who owns the issued read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner   <= OWN_IDLE;
      rd_pend <= RD_NONE;
      c_wait  <= 4'd0;
      d_wait  <= 4'd0;
    end else begin
      if (c_gnt)      owner <= OWN_CPU;
      else if (d_gnt) owner <= OWN_DMA;
      else            owner <= OWN_IDLE;

      if (c_gnt && !c_we)      rd_pend <= RD_C;
      else if (d_gnt && !d_we) rd_pend <= RD_D;
      else                     rd_pend <= RD_NONE;

      c_wait <= (c_req && !c_gnt) ? sat_inc(c_wait) : 4'd0;
      d_wait <= (d_req && !d_gnt) ? sat_inc(d_wait) : 4'd0;
    end
  end

  assign c_rvalid = (rd_pend == RD_C);
  assign d_rvalid = (rd_pend == RD_D);
  assign rdata    = reset ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, c_gnt, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          d_req, d_we, d_lock, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // Synchronous memory: unwritten words read back as 0xD0000000 | address.
  logic [DW-1:0] mem [256];
  bit   [255:0]  written;
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[7:0]]     <= mem_wdata;
      written[mem_addr[7:0]] <= 1'b1;
    end
    if (mem_read)
      mem_rdata <= written[mem_addr[7:0]] ? mem[mem_addr[7:0]] : (32'hD000_0000 | mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_lock = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    c_req = 1'b1; d_req = 1'b1; c_addr = 32'h10; d_addr = 32'h20;
    @(negedge clk);
    #1;
    checks++; if (c_gnt !== 1'b0) begin errors++; $display("FAIL rst_cgnt: got %b exp 0", c_gnt); end
    checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL rst_dgnt: got %b exp 0", d_gnt); end
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL rst_strobes: got %b%b exp 00", mem_read, mem_write); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", mem_addr); end
    checks++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b exp 00", c_rvalid, d_rvalid); end
    @(negedge clk);
    idle();
    reset = 1'b1;
    tick();
    #1;
    checks++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL post_rst_rvalid: got %b%b exp 00", c_rvalid, d_rvalid); end
  endtask

  task automatic test_cpu_write_read();
    idle(); tick(); tick();
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'hA5;
    #1;
    checks++; if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt: got c=%b d=%b exp c=1 d=0", c_gnt, d_gnt); end
    checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL wr_strobe: got w=%b r=%b exp w=1 r=0", mem_write, mem_read); end
    checks++; if (mem_addr !== 32'h10 || mem_wdata !== 32'hA5) begin errors++; $display("FAIL wr_cmd: got %h/%h exp 10/a5", mem_addr, mem_wdata); end
    tick();
    c_we = 1'b0;
    #1;
    checks++; if (c_gnt !== 1'b1 || mem_read !== 1'b1) begin errors++; $display("FAIL rd_gnt: got gnt=%b rd=%b exp 1/1", c_gnt, mem_read); end
    checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b exp 0", c_rvalid); end
    tick();
    idle();
    #1;
    checks++; if (c_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid: got c=%b d=%b exp c=1 d=0", c_rvalid, d_rvalid); end
    checks++; if (rdata !== 32'hA5) begin errors++; $display("FAIL rd_data: got %h exp a5", rdata); end
  endtask

  task automatic test_starvation();
    logic [9:0] exp_d;
    logic       prev_c, prev_d;
    exp_d = 10'b10_0001_0000;
    idle(); tick(); tick();
    prev_c = 1'b0; prev_d = 1'b0;
    c_req = 1'b1; c_addr = 32'h20; d_req = 1'b1; d_addr = 32'h30;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++; if (d_gnt !== exp_d[k]) begin errors++; $display("FAIL starve_dgnt[%0d]: got %b exp %b", k, d_gnt, exp_d[k]); end
      checks++; if (c_gnt !== !exp_d[k]) begin errors++; $display("FAIL starve_cgnt[%0d]: got %b exp %b", k, c_gnt, !exp_d[k]); end
      checks++; if (c_rvalid !== prev_c || d_rvalid !== prev_d) begin errors++; $display("FAIL starve_rvalid[%0d]: got %b%b exp %b%b", k, c_rvalid, d_rvalid, prev_c, prev_d); end
      prev_c = !exp_d[k];
      prev_d = exp_d[k];
      tick();
    end
    idle();
    #1;
    checks++; if (d_rvalid !== 1'b1 || rdata !== 32'hD000_0030) begin errors++; $display("FAIL starve_last: got v=%b %h exp v=1 d0000030", d_rvalid, rdata); end
  endtask

  task automatic test_lock_burst();
    logic [9:0]    exp_d, exp_c;
    logic          prev_c, prev_d;
    logic [AW-1:0] prev_addr;
    int            ptr;
    exp_d = 10'b01_1101_1111;
    exp_c = 10'b00_0010_0000;
    idle(); tick(); tick();
    prev_c = 1'b0; prev_d = 1'b0; prev_addr = '0; ptr = 0;
    for (int k = 0; k < 10; k++) begin
      d_req  = (ptr < 8);
      d_addr = 32'h40 + ptr;
      d_lock = 1'b1;
      c_req  = (k >= 1 && k <= 5);
      c_addr = 32'h50;
      #1;
      checks++; if (d_gnt !== exp_d[k] || c_gnt !== exp_c[k]) begin errors++; $display("FAIL lock_gnt[%0d]: got c=%b d=%b exp c=%b d=%b", k, c_gnt, d_gnt, exp_c[k], exp_d[k]); end
      if (exp_d[k]) begin
        checks++; if (mem_addr !== 32'h40 + ptr || mem_read !== 1'b1) begin errors++; $display("FAIL lock_cmd[%0d]: got %h r=%b exp %h r=1", k, mem_addr, mem_read, 32'h40 + ptr); end
      end
      checks++; if (d_rvalid !== prev_d || c_rvalid !== prev_c) begin errors++; $display("FAIL lock_rvalid[%0d]: got c=%b d=%b exp c=%b d=%b", k, c_rvalid, d_rvalid, prev_c, prev_d); end
      if (prev_d) begin
        checks++; if (rdata !== (32'hD000_0000 | prev_addr)) begin errors++; $display("FAIL lock_data[%0d]: got %h exp %h", k, rdata, 32'hD000_0000 | prev_addr); end
      end
      if (prev_c) begin
        checks++; if (rdata !== 32'hD000_0050) begin errors++; $display("FAIL lock_cdata[%0d]: got %h exp d0000050", k, rdata); end
      end
      prev_d = exp_d[k];
      prev_c = exp_c[k];
      prev_addr = 32'h40 + ptr;
      if (exp_d[k]) ptr++;
      tick();
    end
    idle();
  endtask

  task automatic test_back_to_back();
    idle(); tick(); tick();
    c_req = 1'b1; c_addr = 32'h60;
    #1;
    checks++; if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL b2b_c: got c=%b d=%b exp 1/0", c_gnt, d_gnt); end
    tick();
    idle();
    d_req = 1'b1; d_addr = 32'h61;
    #1;
    checks++; if (d_gnt !== 1'b1 || c_gnt !== 1'b0) begin errors++; $display("FAIL b2b_d: got c=%b d=%b exp 0/1", c_gnt, d_gnt); end
    checks++; if (c_rvalid !== 1'b1 || rdata !== 32'hD000_0060) begin errors++; $display("FAIL b2b_cret: got v=%b %h exp v=1 d0000060", c_rvalid, rdata); end
    tick();
    d_we = 1'b1; d_addr = 32'h62; d_wdata = 32'h1234;
    #1;
    checks++; if (d_rvalid !== 1'b1 || c_rvalid !== 1'b0 || rdata !== 32'hD000_0061) begin errors++; $display("FAIL b2b_dret: got c=%b d=%b %h exp 0/1 d0000061", c_rvalid, d_rvalid, rdata); end
    checks++; if (mem_write !== 1'b1 || mem_addr !== 32'h62 || mem_wdata !== 32'h1234) begin errors++; $display("FAIL b2b_dwr: got w=%b %h/%h exp 1 62/1234", mem_write, mem_addr, mem_wdata); end
    tick();
    idle();
    c_req = 1'b1; c_addr = 32'h62;
    #1;
    checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_wr_norv: got %b exp 0", d_rvalid); end
    tick();
    idle();
    #1;
    checks++; if (c_rvalid !== 1'b1 || rdata !== 32'h1234) begin errors++; $display("FAIL b2b_rdback: got v=%b %h exp v=1 1234", c_rvalid, rdata); end
  endtask

  task automatic test_reset_mid_read();
    logic [4:0] exp_d;
    exp_d = 5'b10000;
    idle(); tick(); tick();
    c_req = 1'b1; c_addr = 32'h70; d_req = 1'b1; d_addr = 32'h71;
    #1;
    checks++; if (c_gnt !== 1'b1) begin errors++; $display("FAIL mid_g0: got %b exp 1", c_gnt); end
    tick();
    #1;
    checks++; if (c_gnt !== 1'b1 || c_rvalid !== 1'b1 || rdata !== 32'hD000_0070) begin errors++; $display("FAIL mid_g1: got g=%b v=%b %h exp 1 1 d0000070", c_gnt, c_rvalid, rdata); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid: got %b%b exp 00", c_rvalid, d_rvalid); end
    checks++; if (c_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL mid_gnt: got %b%b r=%b exp 00 r=0", c_gnt, d_gnt, mem_read); end
    checks++; if (rdata !== 32'h0 || mem_addr !== 32'h0) begin errors++; $display("FAIL mid_data: got %h/%h exp 0/0", rdata, mem_addr); end
    tick(); tick();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k == 0) begin
        checks++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL mid_release_rv: got %b%b exp 00", c_rvalid, d_rvalid); end
      end
      checks++; if (d_gnt !== exp_d[k] || c_gnt !== !exp_d[k]) begin errors++; $display("FAIL mid_restart[%0d]: got c=%b d=%b exp d=%b", k, c_gnt, d_gnt, exp_d[k]); end
      tick();
    end
    idle();
  endtask

  task automatic test_idle();
    idle(); tick(); tick();
    d_lock = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || c_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL idle[%0d]: got r=%b w=%b g=%b%b a=%h exp all 0", k, mem_read, mem_write, c_gnt, d_gnt, mem_addr); end
      tick();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_cpu_write_read();
    test_starvation();
    test_lock_burst();
    test_back_to_back();
    test_reset_mid_read();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
